// File: rtl/game_timer_ctrl_pkg.sv
// Shared types, BCD limits and packed MM:SS field positions for the game timer.
package game_timer_ctrl_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned TIME_W  = 16;

  localparam int unsigned SEC_ONES_LSB = 0;
  localparam int unsigned SEC_TENS_LSB = 4;
  localparam int unsigned MIN_ONES_LSB = 8;
  localparam int unsigned MIN_TENS_LSB = 12;

  localparam logic [DIGIT_W-1:0] BCD_MAX_ONES = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MAX_TENS = 4'd5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'b00;
  localparam state_t ST_RUN     = 2'b01;
  localparam state_t ST_PAUSE   = 2'b10;
  localparam state_t ST_EXPIRED = 2'b11;

  // A loadable MM:SS value: every digit is decimal and seconds stay below 60.
  function automatic logic bcd_valid(input logic [TIME_W-1:0] v);
    return (v[MIN_TENS_LSB +: DIGIT_W] <= BCD_MAX_ONES) &&
           (v[MIN_ONES_LSB +: DIGIT_W] <= BCD_MAX_ONES) &&
           (v[SEC_TENS_LSB +: DIGIT_W] <= BCD_MAX_TENS) &&
           (v[SEC_ONES_LSB +: DIGIT_W] <= BCD_MAX_ONES);
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// Single down-counting BCD digit; wraps 0 -> MAX_VAL and raises a borrow to the next stage.
module bcd_digit_dn
  import game_timer_ctrl_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX_VAL = BCD_MAX_ONES
) (
  input  logic               clk_50MHz_i,
  input  logic               rst_sync_i,
  input  logic               en,
  input  logic               borrow_in,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_out_c
);

  assign borrow_out_c = borrow_in && (digit == '0);

  // Load takes precedence so a reload can coincide with the final decrement.
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_i) begin
      digit <= '0;
    end else if (load) begin
      digit <= load_val;
    end else if (en && borrow_in) begin
      digit <= (digit == '0) ? MAX_VAL : digit - DIGIT_W'(1);
    end
  end

endmodule

// File: rtl/game_timer_ctrl.sv
// MM:SS countdown timer controller with prescaler, command FSM and BCD digit cascade.
// Optional build macro GAME_TIMER_AUTO_RELOAD_EN: reload from the shadow value on expiry.
module game_timer_ctrl
  import game_timer_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned TICK_DW  = 26
) (
  input  logic              clk_50MHz_i,
  input  logic              rst_sync_i,
  input  logic              start_i,
  input  logic              pause_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_bcd_i,
  output logic [TIME_W-1:0] time_bcd_o,
  output logic [1:0]        state_o,
  output logic              tick_o,
  output logic              done_o,
  output logic              load_err_o,
  output logic              running_o
);

  state_t             state_q, state_nxt;
  logic [TICK_DW-1:0] presc_q, presc_nxt;
  logic               tick_nxt, done_nxt, err_nxt;
  logic               ld_c, dec_c;
  logic [TIME_W-1:0]  ld_val_c;
  logic [TIME_W-1:0]  time_q;
  logic               presc_wrap_c, time_zero_c, time_last_c;
  logic               b_so_c, b_st_c, b_mo_c, b_mt_c;

`ifdef GAME_TIMER_AUTO_RELOAD_EN
  logic [TIME_W-1:0] shadow_q;

  // Shadow copy of the last accepted load, used as the reload value.
  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_i) begin
      shadow_q <= '0;
    end else if ((state_q == ST_IDLE) && !clear_i && !pause_i && !start_i &&
                 load_i && bcd_valid(load_bcd_i)) begin
      shadow_q <= load_bcd_i;
    end
  end
`endif

  assign presc_wrap_c = (presc_q == TICK_DW'(TICK_DIV - 1));
  assign time_zero_c  = (time_q == '0);
  assign time_last_c  = (time_q == TIME_W'(1));

  // Next-state, prescaler and digit-control decode; clear > pause > start > load.
  always_comb begin
    state_nxt = state_q;
    presc_nxt = presc_q;
    tick_nxt  = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    ld_c      = 1'b0;
    ld_val_c  = '0;
    dec_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          ld_c      = 1'b1;
          presc_nxt = '0;
        end else if (!pause_i) begin
          if (start_i) begin
            if (!time_zero_c) begin
              state_nxt = ST_RUN;
              presc_nxt = '0;
            end
          end else if (load_i) begin
            if (bcd_valid(load_bcd_i)) begin
              ld_c     = 1'b1;
              ld_val_c = load_bcd_i;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        if (clear_i) begin
          state_nxt = ST_IDLE;
          ld_c      = 1'b1;
          presc_nxt = '0;
        end else begin
          presc_nxt = presc_wrap_c ? '0 : presc_q + TICK_DW'(1);
          if (presc_wrap_c) begin
            tick_nxt = 1'b1;
            dec_c    = !time_zero_c;
          end
          if (presc_wrap_c && time_last_c) begin
            done_nxt = 1'b1;
`ifdef GAME_TIMER_AUTO_RELOAD_EN
            ld_c     = 1'b1;
            ld_val_c = shadow_q;
`else
            state_nxt = ST_EXPIRED;
`endif
          end else if (pause_i) begin
            state_nxt = ST_PAUSE;
          end
        end
      end
      ST_PAUSE: begin
        if (clear_i) begin
          state_nxt = ST_IDLE;
          ld_c      = 1'b1;
          presc_nxt = '0;
        end else if (!pause_i && start_i) begin
          state_nxt = ST_RUN;
        end
      end
      default: begin
        if (clear_i) begin
          state_nxt = ST_IDLE;
          ld_c      = 1'b1;
          presc_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_50MHz_i) begin
    if (rst_sync_i) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      tick_o     <= 1'b0;
      done_o     <= 1'b0;
      load_err_o <= 1'b0;
      running_o  <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      presc_q    <= presc_nxt;
      tick_o     <= tick_nxt;
      done_o     <= done_nxt;
      load_err_o <= err_nxt;
      running_o  <= (state_nxt == ST_RUN);
    end
  end

  bcd_digit_dn #(.MAX_VAL(BCD_MAX_ONES)) u_sec_ones (
    .clk_50MHz_i (clk_50MHz_i),
    .rst_sync_i  (rst_sync_i),
    .en          (dec_c),
    .borrow_in   (1'b1),
    .load        (ld_c),
    .load_val    (ld_val_c[SEC_ONES_LSB +: DIGIT_W]),
    .digit       (time_q[SEC_ONES_LSB +: DIGIT_W]),
    .borrow_out_c(b_so_c)
  );

  bcd_digit_dn #(.MAX_VAL(BCD_MAX_TENS)) u_sec_tens (
    .clk_50MHz_i (clk_50MHz_i),
    .rst_sync_i  (rst_sync_i),
    .en          (dec_c),
    .borrow_in   (b_so_c),
    .load        (ld_c),
    .load_val    (ld_val_c[SEC_TENS_LSB +: DIGIT_W]),
    .digit       (time_q[SEC_TENS_LSB +: DIGIT_W]),
    .borrow_out_c(b_st_c)
  );

  bcd_digit_dn #(.MAX_VAL(BCD_MAX_ONES)) u_min_ones (
    .clk_50MHz_i (clk_50MHz_i),
    .rst_sync_i  (rst_sync_i),
    .en          (dec_c),
    .borrow_in   (b_st_c),
    .load        (ld_c),
    .load_val    (ld_val_c[MIN_ONES_LSB +: DIGIT_W]),
    .digit       (time_q[MIN_ONES_LSB +: DIGIT_W]),
    .borrow_out_c(b_mo_c)
  );

  // Top digit never borrows further: 0000 is never decremented.
  bcd_digit_dn #(.MAX_VAL(BCD_MAX_ONES)) u_min_tens (
    .clk_50MHz_i (clk_50MHz_i),
    .rst_sync_i  (rst_sync_i),
    .en          (dec_c),
    .borrow_in   (b_mo_c),
    .load        (ld_c),
    .load_val    (ld_val_c[MIN_TENS_LSB +: DIGIT_W]),
    .digit       (time_q[MIN_TENS_LSB +: DIGIT_W]),
    .borrow_out_c(b_mt_c)
  );

  assign time_bcd_o = time_q;
  assign state_o    = state_q;

  logic unused_ok;
  assign unused_ok = b_mt_c;

endmodule
